// File: rtl/detect_faces_div_pkg.sv
// rtl/detect_faces_div_pkg.sv - shared widths, state encoding and constants for the 64/32 divider
package detect_faces_div_pkg;

  localparam int DIVIDEND_W = 64;
  localparam int DIVISOR_W  = 32;
  localparam int REM_W      = 33;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  localparam logic [DIVIDEND_W-1:0] DIV_ZERO_QUOTIENT = '1;
  localparam logic [CNT_W-1:0]      LAST_STEP         = '1;

endpackage

// File: rtl/detect_faces_div_step.sv
// rtl/detect_faces_div_step.sv - one combinational radix-2 restoring division step
module detect_faces_div_step
  import detect_faces_div_pkg::*;
#(
  parameter int DW = DIVIDEND_W,
  parameter int VW = DIVISOR_W
) (
  input  logic [VW:0]   rem,
  input  logic [DW-1:0] quo,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   rem_next,
  output logic [DW-1:0] quo_next
);

  logic [VW:0] shifted;
  logic [VW:0] trial;
  logic        fits;

  // A set top remainder bit means the shifted value exceeds any 32-bit divisor.
  assign shifted  = {rem[VW-1:0], quo[DW-1]};
  assign trial    = shifted - {1'b0, divisor};
  assign fits     = rem[VW] | (shifted >= {1'b0, divisor});
  assign rem_next = fits ? trial : shifted;
  assign quo_next = {quo[DW-2:0], fits};

endmodule

// File: rtl/detect_faces_udiv_64ns_32ns_seq.sv
// rtl/detect_faces_udiv_64ns_32ns_seq.sv - sequential 64/32 unsigned divider with valid/ready and ce
module detect_faces_udiv_64ns_32ns_seq
  import detect_faces_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DIVIDEND_W,
  parameter int DIVISOR_WIDTH  = DIVISOR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero
);

  div_state_t                state;
  logic [CNT_W-1:0]          cnt;
  logic [DIVISOR_WIDTH:0]    rem_q;
  logic [DIVIDEND_WIDTH-1:0] quo_q;
  logic [DIVISOR_WIDTH-1:0]  div_q;
  logic                      dbz_q;
  logic [DIVISOR_WIDTH:0]    rem_nxt;
  logic [DIVIDEND_WIDTH-1:0] quo_nxt;

  detect_faces_div_step #(
    .DW (DIVIDEND_WIDTH),
    .VW (DIVISOR_WIDTH)
  ) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (div_q),
    .rem_next (rem_nxt),
    .quo_next (quo_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      dbz_q <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              // Zero divisor skips the iteration and reports a saturated quotient.
              quo_q <= DIV_ZERO_QUOTIENT;
              rem_q <= {1'b0, dividend[DIVISOR_WIDTH-1:0]};
              dbz_q <= 1'b1;
              state <= DONE;
            end else begin
              quo_q <= dividend;
              rem_q <= '0;
              div_q <= divisor;
              cnt   <= '0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_STEP) state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
            dbz_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q[DIVISOR_WIDTH-1:0];
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_detect_faces_udiv_64ns_32ns_seq.sv
// tb/tb_detect_faces_udiv_64ns_32ns_seq.sv - randomized self-checking bench for the 64/32 divider
module tb_detect_faces_udiv_64ns_32ns_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ce = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int tests = 0;
  int fails = 0;

  detect_faces_udiv_64ns_32ns_seq dut (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, summary %0d tests, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ref_quo(input logic [63:0] a, input logic [31:0] b);
    if (b == 0) return 64'hFFFF_FFFF_FFFF_FFFF;
    return a / {32'd0, b};
  endfunction

  function automatic logic [31:0] ref_rem(input logic [63:0] a, input logic [31:0] b);
    logic [63:0] r;
    if (b == 0) return a[31:0];
    r = a % {32'd0, b};
    return r[31:0];
  endfunction

  // Accept one operand pair with ce high, then wait (bounded) for out_valid; lat counts edges after the accept edge.
  task automatic do_op(input logic [63:0] a, input logic [31:0] b, output int lat, output bit ok);
    @(negedge clk);
    ce = 1'b1; out_ready = 1'b0; in_valid = 1'b1; dividend = a; divisor = b;
    ok = in_ready;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; dividend = {$urandom, $urandom}; divisor = $urandom;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    ok = ok && out_valid;
  endtask

  task automatic consume();
    ce = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    tests++;
    if (quotient !== 64'd0 || remainder !== 32'd0 || div_by_zero !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got q=%h r=%h dbz=%b ov=%b, want all 0", quotient, remainder, div_by_zero, out_valid);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int lat; bit ok;
    do_op(64'd100, 32'd7, lat, ok);
    tests++;
    if (!ok || quotient !== 64'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
      fails++; $display("FAIL basic_100_7: got ok=%b q=%0d r=%0d dbz=%b want q=14 r=2 dbz=0", ok, quotient, remainder, div_by_zero);
    end
    tests++;
    if (lat != 64) begin
      fails++; $display("FAIL basic_latency: got %0d want 64", lat);
    end
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL basic_exclusive: in_ready=%b while out_valid, want 0", in_ready);
    end
    consume();
  endtask

  task automatic test_extremes();
    logic [31:0] divs [2];
    logic [63:0] expq [2];
    int lat; bit ok;
    divs[0] = 32'd1;          expq[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    divs[1] = 32'hFFFF_FFFF;  expq[1] = 64'h0000_0001_0000_0001;
    for (int i = 0; i < 2; i++) begin
      do_op(64'hFFFF_FFFF_FFFF_FFFF, divs[i], lat, ok);
      tests++;
      if (!ok || quotient !== expq[i] || remainder !== 32'd0 || lat != 64) begin
        fails++; $display("FAIL extreme_%0d: got ok=%b q=%h r=%h lat=%0d want q=%h r=0 lat=64", i, ok, quotient, remainder, lat, expq[i]);
      end
      consume();
    end
  endtask

  task automatic test_zero_div();
    int lat; bit ok;
    do_op(64'd12345, 32'd0, lat, ok);
    tests++;
    if (!ok || quotient !== 64'hFFFF_FFFF_FFFF_FFFF || remainder !== 32'd12345 || div_by_zero !== 1'b1) begin
      fails++; $display("FAIL zero_div: got ok=%b q=%h r=%0d dbz=%b want q=all ones r=12345 dbz=1", ok, quotient, remainder, div_by_zero);
    end
    tests++;
    if (lat != 0) begin
      fails++; $display("FAIL zero_div_latency: got %0d want 0", lat);
    end
    consume();
    tests++;
    if (div_by_zero !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL zero_div_clear: got dbz=%b in_ready=%b want 0 1", div_by_zero, in_ready);
    end
  endtask

  task automatic test_backpressure();
    int lat; bit ok; int bad;
    do_op(64'd1000, 32'd3, lat, ok);
    bad = ok ? 0 : 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 64'd333 || remainder !== 32'd1) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL backpressure_hold: %0d bad cycles, last ov=%b ir=%b q=%0d r=%0d want 1 0 333 1", bad, out_valid, in_ready, quotient, remainder);
    end
    consume();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL backpressure_release: got ir=%b ov=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_ce_gating();
    int lat; int lows; int unstable;
    logic [63:0] pq; logic [31:0] pr; logic pv, pi;
    @(negedge clk);
    ce = 1'b1; in_valid = 1'b1; dividend = 64'd1 << 40; divisor = 32'd16;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    lat = 0; lows = 0; unstable = 0;
    while (!out_valid && lat < 400) begin
      ce = $urandom_range(0, 1);
      pq = quotient; pr = remainder; pv = out_valid; pi = in_ready;
      @(posedge clk); lat++;
      if (!ce) lows++;
      @(negedge clk);
      if (!ce && (quotient !== pq || remainder !== pr || out_valid !== pv || in_ready !== pi)) unstable++;
    end
    tests++;
    if (out_valid !== 1'b1 || quotient !== (64'd1 << 36) || remainder !== 32'd0) begin
      fails++; $display("FAIL ce_result: got ov=%b q=%h r=%0d want 1 %h 0", out_valid, quotient, remainder, 64'd1 << 36);
    end
    tests++;
    if (lat != 64 + lows) begin
      fails++; $display("FAIL ce_latency: got %0d want %0d", lat, 64 + lows);
    end
    tests++;
    if (unstable != 0) begin
      fails++; $display("FAIL ce_freeze: %0d cycles changed with ce low, want 0", unstable);
    end
    ce = 1'b0; out_ready = 1'b1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    tests++;
    if (out_valid !== 1'b1 || quotient !== (64'd1 << 36)) begin
      fails++; $display("FAIL ce_done_hold: got ov=%b q=%h want 1 %h", out_valid, quotient, 64'd1 << 36);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int lat; bit ok; int seen;
    @(negedge clk);
    ce = 1'b1; in_valid = 1'b1; dividend = 64'd500; divisor = 32'd9;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (30) begin @(posedge clk); @(negedge clk); end
    reset = 1'b0;
    #1;
    tests++;
    if (quotient !== 64'd0 || remainder !== 32'd0 || div_by_zero !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_mid_outputs: got q=%h r=%h dbz=%b ov=%b want 0", quotient, remainder, div_by_zero, out_valid);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (80) begin @(posedge clk); @(negedge clk); if (out_valid) seen++; end
    tests++;
    if (seen != 0) begin
      fails++; $display("FAIL reset_mid_no_valid: got %0d valid cycles want 0", seen);
    end
    do_op(64'd500, 32'd9, lat, ok);
    tests++;
    if (!ok || quotient !== 64'd55 || remainder !== 32'd5 || lat != 64) begin
      fails++; $display("FAIL reset_mid_fresh: got ok=%b q=%0d r=%0d lat=%0d want 55 5 64", ok, quotient, remainder, lat);
    end
    consume();
  endtask

  task automatic test_random();
    logic [63:0] a; logic [31:0] b;
    int lat; bit ok;
    for (int i = 0; i < 24; i++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 255);
        3:       a = a >> $urandom_range(0, 63);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 3) b = $urandom | 32'h8000_0000;
      do_op(a, b, lat, ok);
      tests++;
      if (!ok || quotient !== ref_quo(a, b) || remainder !== ref_rem(a, b) ||
          div_by_zero !== (b == 0) || lat != ((b == 0) ? 0 : 64)) begin
        fails++;
        $display("FAIL random_%0d %h/%h: got ok=%b q=%h r=%h dbz=%b lat=%0d want q=%h r=%h dbz=%b", i, a, b,
                 ok, quotient, remainder, div_by_zero, lat, ref_quo(a, b), ref_rem(a, b), b == 0);
      end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] qa[$]; logic [31:0] qb[$];
    logic [63:0] a; logic [31:0] b;
    int cyc; int last; int results; int both; int wait_n;
    @(negedge clk);
    ce = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    last = -1; results = 0; both = 0;
    for (cyc = 0; cyc < 210; cyc++) begin
      if (out_valid && in_ready) both++;
      if (out_valid) begin
        a = qa.pop_front(); b = qb.pop_front();
        tests++;
        if (quotient !== ref_quo(a, b) || remainder !== ref_rem(a, b) || div_by_zero !== 1'b0) begin
          fails++; $display("FAIL b2b_result %h/%h: got q=%h r=%h want q=%h r=%h", a, b, quotient, remainder, ref_quo(a, b), ref_rem(a, b));
        end
        if (last >= 0) begin
          tests++;
          if (cyc - last != 66) begin
            fails++; $display("FAIL b2b_interval: got %0d cycles want 66", cyc - last);
          end
        end
        last = cyc; results++;
      end
      dividend = {$urandom, $urandom};
      divisor = $urandom | 32'd1;
      if (in_ready) begin qa.push_back(dividend); qb.push_back(divisor); end
      @(posedge clk); @(negedge clk);
    end
    tests++;
    if (results != 3 || both != 0) begin
      fails++; $display("FAIL b2b_count: got %0d results, %0d overlap cycles, want 3 and 0", results, both);
    end
    in_valid = 1'b0;
    wait_n = 0;
    while (!in_ready && wait_n < 100) begin @(posedge clk); @(negedge clk); wait_n++; end
    out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_drain: in_ready=%b want 1", in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_zero_div();
    test_backpressure();
    test_ce_gating();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
